// File: rtl/dec_counter_pkg.sv
// Shared types and constants for the parametrised down-counter.
package dec_counter_pkg;

    typedef enum logic {IDLE, COUNT} state_t;
    typedef enum logic {MODE_ONESHOT, MODE_RELOAD} mode_t;

    localparam int unsigned RELOAD_CNT_W = 16;

endpackage

// File: rtl/dec_counter_param.sv
// Parametrised down-counter with valid/ready threshold load, one-shot/auto-reload and abort.
// Optional reload-event counter output enabled by defining DEC_COUNTER_RELOAD_CNT_EN.
module dec_counter_param
    import dec_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned RST_MODE = 0
) (
    input  logic             clk,
    input  logic             i_arst,
    input  logic             i_threshold_val,
    input  logic [WIDTH-1:0] i_threshold,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_stop,
    output logic             o_ready,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_data_counter,
`ifdef DEC_COUNTER_RELOAD_CNT_EN
    output logic [RELOAD_CNT_W-1:0] o_reload_cnt,
`endif
    output logic             o_done
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam mode_t            MODE_RST = (RST_MODE == 0) ? MODE_ONESHOT : MODE_RELOAD;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] thresh_q, thresh_d;
    logic             done_q, done_d;
    logic             load_acc;

    assign load_acc = i_threshold_val && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        thresh_d = thresh_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    thresh_d = i_threshold;
                    mode_d   = mode_t'(i_mode);
                    // A zero threshold is a zero-length period: done without ever counting.
                    if (i_threshold == ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = COUNT;
                        count_d = i_threshold;
                    end
                end
            end
            COUNT: begin
                if (i_stop) begin
                    state_d = IDLE;
                    count_d = ZERO;
                end else if (i_step) begin
                    if (count_q == ONE) begin
                        done_d = 1'b1;
                        if (mode_q == MODE_RELOAD) begin
                            count_d = thresh_q;
                        end else begin
                            count_d = ZERO;
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_RST;
            count_q  <= ZERO;
            thresh_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            thresh_q <= thresh_d;
            done_q   <= done_d;
        end
    end

    assign o_ready        = (state_q == IDLE);
    assign o_busy         = (state_q == COUNT);
    assign o_data_counter = count_q;
    assign o_done         = done_q;

`ifdef DEC_COUNTER_RELOAD_CNT_EN
    logic [RELOAD_CNT_W-1:0] reload_cnt_q, reload_cnt_d;

    // A done produced while counting in reload mode is a reload event; loads restart the tally.
    always_comb begin
        reload_cnt_d = reload_cnt_q;
        if (load_acc) begin
            reload_cnt_d = '0;
        end else if (done_d && (mode_q == MODE_RELOAD) && (reload_cnt_q != {RELOAD_CNT_W{1'b1}})) begin
            reload_cnt_d = reload_cnt_q + RELOAD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            reload_cnt_q <= '0;
        end else begin
            reload_cnt_q <= reload_cnt_d;
        end
    end

    assign o_reload_cnt = reload_cnt_q;
`endif

endmodule

// File: tb/tb_dec_counter_param.sv
// Directed scoreboard bench for dec_counter_param (WIDTH=4 primary instance, WIDTH=8 for full-range count).
module tb_dec_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       val;
    logic [7:0] thr;
    logic       mode;
    logic       step;
    logic       stop;

    logic       ready4, busy4, done4;
    logic [3:0] cnt4;
    logic       ready8, busy8, done8;
    logic [7:0] cnt8;
`ifdef DEC_COUNTER_RELOAD_CNT_EN
    logic [15:0] rc4, rc8;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       busy;
        logic [3:0] cnt;
        logic       done;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dec_counter_param #(.WIDTH(4), .RST_MODE(0)) u_dut4 (
        .clk             (clk),
        .i_arst          (rst),
        .i_threshold_val (val),
        .i_threshold     (thr[3:0]),
        .i_mode          (mode),
        .i_step          (step),
        .i_stop          (stop),
        .o_ready         (ready4),
        .o_busy          (busy4),
        .o_data_counter  (cnt4),
`ifdef DEC_COUNTER_RELOAD_CNT_EN
        .o_reload_cnt    (rc4),
`endif
        .o_done          (done4)
    );

    dec_counter_param #(.WIDTH(8), .RST_MODE(0)) u_dut8 (
        .clk             (clk),
        .i_arst          (rst),
        .i_threshold_val (val),
        .i_threshold     (thr),
        .i_mode          (mode),
        .i_step          (step),
        .i_stop          (stop),
        .o_ready         (ready8),
        .o_busy          (busy8),
        .o_data_counter  (cnt8),
`ifdef DEC_COUNTER_RELOAD_CNT_EN
        .o_reload_cnt    (rc8),
`endif
        .o_done          (done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic b, input logic [3:0] c, input logic d);
        exp_t e;
        e.tag  = tag;
        e.busy = b;
        e.cnt  = c;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare the oldest scoreboard entry against the WIDTH=4 instance.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_busy"},  busy4,  e.busy);
            chk({e.tag, "_ready"}, ready4, !e.busy);
            chk({e.tag, "_cnt"},   cnt4,   e.cnt);
            chk({e.tag, "_done"},  done4,  e.done);
        end
    endtask

    task automatic load(input logic [7:0] n, input logic m);
        val  = 1'b1;
        thr  = n;
        mode = m;
        $display("load threshold=%0d mode=%0d at %0t", n, m, $time);
    endtask

    initial begin
        int edges;
        rst = 1'b1; val = 1'b0; thr = '0; mode = 1'b0; step = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", ready4, 1'b1);
        chk("rst_busy",  busy4,  1'b0);
        chk("rst_cnt",   cnt4,   4'd0);
        chk("rst_done",  done4,  1'b0);
        push("idle", 1'b0, 4'd0, 1'b0); tick();

        // Asynchronous reset in the middle of a count
        load(8'd9, 1'b0);
        push("arst_load", 1'b1, 4'd9, 1'b0); tick();
        val = 1'b0; step = 1'b1;
        for (int k = 8; k >= 6; k--) begin
            push("arst_step", 1'b1, 4'(k), 1'b0); tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt",   cnt4,   4'd0);
        chk("arst_busy",  busy4,  1'b0);
        chk("arst_ready", ready4, 1'b1);
        chk("arst_cnt8",  cnt8,   8'd0);
        #1 rst = 1'b0;
        step = 1'b0;
        push("post_arst", 1'b0, 4'd0, 1'b0); tick();

        // Zero-length load
        load(8'd0, 1'b0);
        push("zero_load", 1'b0, 4'd0, 1'b1); tick();
        val = 1'b0;
        push("zero_after", 1'b0, 4'd0, 1'b0); tick();

        // Stop while idle has no effect
        stop = 1'b1;
        push("stop_idle", 1'b0, 4'd0, 1'b0); tick();
        stop = 1'b0;

        // One-shot 14 with continuous steps
        load(8'd14, 1'b0); step = 1'b1;
        push("os_load", 1'b1, 4'd14, 1'b0); tick();
        val = 1'b0;
        for (int k = 13; k >= 1; k--) begin
            push("os_step", 1'b1, 4'(k), 1'b0); tick();
        end
        push("os_done", 1'b0, 4'd0, 1'b1); tick();
        push("os_idle", 1'b0, 4'd0, 1'b0); tick();

        // Auto-reload 3 with nine steps, then abort
        load(8'd3, 1'b1);
        push("ar_load", 1'b1, 4'd3, 1'b0); tick();
        val = 1'b0;
        for (int r = 0; r < 3; r++) begin
            push("ar_2", 1'b1, 4'd2, 1'b0); tick();
            push("ar_1", 1'b1, 4'd1, 1'b0); tick();
            push("ar_3", 1'b1, 4'd3, 1'b1); tick();
        end
`ifdef DEC_COUNTER_RELOAD_CNT_EN
        chk("ar_reload_cnt", rc4, 16'd3);
`endif
        step = 1'b0; stop = 1'b1;
        push("ar_stop", 1'b0, 4'd0, 1'b0); tick();
        stop = 1'b0;

        // Auto-reload 1: done on every step
        load(8'd1, 1'b1); step = 1'b1;
        push("ar1_load", 1'b1, 4'd1, 1'b0); tick();
        val = 1'b0;
        for (int r = 0; r < 3; r++) begin
            push("ar1_pulse", 1'b1, 4'd1, 1'b1); tick();
        end
`ifdef DEC_COUNTER_RELOAD_CNT_EN
        chk("ar1_reload_cnt", rc4, 16'd3);
`endif
        step = 1'b0; stop = 1'b1;
        push("ar1_stop", 1'b0, 4'd0, 1'b0); tick();
        stop = 1'b0;

        // Stalled steps, then stop coincident with the final step
        load(8'd5, 1'b0);
        push("st_load", 1'b1, 4'd5, 1'b0); tick();
        val = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            step = 1'b1;
            push("st_step", 1'b1, 4'(k), 1'b0); tick();
            step = 1'b0;
            push("st_hold", 1'b1, 4'(k), 1'b0); tick();
        end
        step = 1'b1; stop = 1'b1;
        push("st_stopwin", 1'b0, 4'd0, 1'b0); tick();
        step = 1'b0; stop = 1'b0;
        push("st_nodone", 1'b0, 4'd0, 1'b0); tick();

        // Load while busy is ignored
        load(8'd5, 1'b0); step = 1'b1;
        push("lb_load", 1'b1, 4'd5, 1'b0); tick();
        val = 1'b0;
        push("lb_4", 1'b1, 4'd4, 1'b0); tick();
        push("lb_3", 1'b1, 4'd3, 1'b0); tick();
        load(8'd9, 1'b0);
        push("lb_2", 1'b1, 4'd2, 1'b0); tick();
        val = 1'b0;
        push("lb_1", 1'b1, 4'd1, 1'b0); tick();
        push("lb_done", 1'b0, 4'd0, 1'b1); tick();
        step = 1'b0;

        // Load and stop together in idle: load wins
        load(8'd4, 1'b0); stop = 1'b1;
        push("ls_load", 1'b1, 4'd4, 1'b0); tick();
        val = 1'b0;
        push("ls_stop", 1'b0, 4'd0, 1'b0); tick();
        stop = 1'b0;

        // Full-range count on the WIDTH=8 instance
        load(8'd255, 1'b0); step = 1'b1;
        @(posedge clk); #1;
        val = 1'b0;
        chk("w8_load_cnt", cnt8, 8'd255);
        edges = 0;
        while (!done8 && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("w8_done_edges", edges, 255);
        chk("w8_cnt_end",  cnt8,  8'd0);
        chk("w8_ready_end", ready8, 1'b1);
        step = 1'b0;
        @(posedge clk); #1;
        chk("w8_done_single", done8, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
